// File: rtl/gpu_bus_pkg.sv
// rtl/gpu_bus_pkg.sv - shared types and helpers for the GPU Wishbone bridge
package gpu_bus_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        ACK,
        UNM
    } bus_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gpu_wb_addr_decode.sv
// rtl/gpu_wb_addr_decode.sv - region index to one-hot target select plus mapped flag
module gpu_wb_addr_decode
    import gpu_bus_pkg::*;
#(
    parameter int NUM_TGT = 4,
    parameter int IDX_W   = (clog2(NUM_TGT) < 1) ? 1 : clog2(NUM_TGT)
) (
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_TGT-1:0] onehot,
    output logic               mapped
);

    always_comb begin
        onehot = '0;
        for (int t = 0; t < NUM_TGT; t++) begin
            if (idx == IDX_W'(t)) onehot[t] = 1'b1;
        end
    end

    assign mapped = (32'(idx) < 32'(NUM_TGT));

endmodule

// File: rtl/gpu_wb_bridge.sv
// rtl/gpu_wb_bridge.sv - Wishbone-classic slave front end fanning out to GPU target regions
// Optional WB_ERR_EN: unmapped accesses terminate with wb_err_o and are counted.
module gpu_wb_bridge
    import gpu_bus_pkg::*;
#(
    parameter int ADDR_W       = 27,
    parameter int NUM_TGT      = 4,
    parameter int DEC_LSB      = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic                           clk_100MHz,
    input  logic                           reset_n,
    input  logic                           wb_cyc_i,
    input  logic                           wb_stb_i,
    input  logic                           wb_we_i,
    input  logic [WB_SEL_W-1:0]            wb_sel_i,
    input  logic [ADDR_W-1:0]              wb_adr_i,
    input  logic [WB_DATA_W-1:0]           wb_dat_i,
    output logic [WB_DATA_W-1:0]           wb_dat_o,
    output logic                           wb_ack_o,
    output logic                           wb_err_o,
    output logic [NUM_TGT-1:0]             o_tgt_we,
    output logic [NUM_TGT-1:0]             o_tgt_re,
    output logic [ADDR_W-1:0]              o_tgt_addr,
    output logic [WB_DATA_W-1:0]           o_tgt_wdata,
    output logic [WB_SEL_W-1:0]            o_tgt_sel,
    input  logic [NUM_TGT*WB_DATA_W-1:0]   i_tgt_rdata
);

    localparam int TGT_IDX_W = (clog2(NUM_TGT) < 1) ? 1 : clog2(NUM_TGT);

    bus_state_t             state;
    logic [2:0]             cnt;
    logic [TGT_IDX_W-1:0]   idx;
    logic [TGT_IDX_W-1:0]   idx_q;
    logic [NUM_TGT-1:0]     dec_onehot;
    logic [NUM_TGT-1:0]     oh_q;
    logic                   dec_mapped;
    logic [WB_DATA_W-1:0]   rd_sel;

    assign idx = wb_adr_i[DEC_LSB +: TGT_IDX_W];

    gpu_wb_addr_decode #(
        .NUM_TGT (NUM_TGT),
        .IDX_W   (TGT_IDX_W)
    ) u_decode (
        .idx    (idx),
        .onehot (dec_onehot),
        .mapped (dec_mapped)
    );

    always_comb begin
        rd_sel = '0;
        for (int t = 0; t < NUM_TGT; t++) begin
            if (idx_q == TGT_IDX_W'(t)) rd_sel = i_tgt_rdata[t*WB_DATA_W +: WB_DATA_W];
        end
    end

`ifdef WB_ERR_EN
    // The spare index just past the last target exposes the unmapped-access counter.
    localparam bit                   STATUS_EN  = NUM_TGT < (1 << TGT_IDX_W);
    localparam logic [TGT_IDX_W-1:0] STATUS_IDX = TGT_IDX_W'(NUM_TGT);

    logic       we_q;
    logic       err_q;
    logic [7:0] unm_cnt;

    assign wb_err_o = err_q;
`else
    assign wb_err_o = 1'b0;
`endif

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            idx_q       <= '0;
            oh_q        <= '0;
            o_tgt_we    <= '0;
            o_tgt_re    <= '0;
            o_tgt_addr  <= '0;
            o_tgt_wdata <= '0;
            o_tgt_sel   <= '0;
            wb_dat_o    <= '0;
            wb_ack_o    <= 1'b0;
`ifdef WB_ERR_EN
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            unm_cnt     <= '0;
`endif
        end else begin
            o_tgt_we <= '0;
            o_tgt_re <= '0;
            wb_ack_o <= 1'b0;
`ifdef WB_ERR_EN
            err_q    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        o_tgt_addr  <= wb_adr_i;
                        o_tgt_wdata <= wb_dat_i;
                        o_tgt_sel   <= wb_sel_i;
                        idx_q       <= idx;
                        oh_q        <= dec_onehot;
`ifdef WB_ERR_EN
                        we_q        <= wb_we_i;
`endif
                        if (!dec_mapped) begin
                            state <= UNM;
                        end else if (wb_we_i) begin
                            state <= WR;
                        end else begin
                            // Read strobe fires on entry so the latency count starts with it.
                            state    <= RD;
                            o_tgt_re <= dec_onehot;
                            cnt      <= 3'(READ_LATENCY);
                        end
                    end
                end
                WR: begin
                    o_tgt_we <= oh_q;
                    wb_ack_o <= 1'b1;
                    state    <= ACK;
                end
                RD: begin
                    if (!wb_cyc_i) begin
                        state <= IDLE;
                    end else if (cnt == 3'd0) begin
                        wb_dat_o <= rd_sel;
                        wb_ack_o <= 1'b1;
                        state    <= ACK;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ACK: begin
                    wb_dat_o <= '0;
                    state    <= IDLE;
                end
                UNM: begin
`ifdef WB_ERR_EN
                    if (STATUS_EN && !we_q && idx_q == STATUS_IDX) begin
                        wb_ack_o <= 1'b1;
                        wb_dat_o <= {{(WB_DATA_W-8){1'b0}}, unm_cnt};
                    end else begin
                        err_q <= 1'b1;
                        if (unm_cnt != 8'hFF) unm_cnt <= unm_cnt + 8'd1;
                    end
`else
                    wb_ack_o <= 1'b1;
                    wb_dat_o <= '0;
`endif
                    state <= ACK;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_wb_bridge.sv
// tb/tb_gpu_wb_bridge.sv - scoreboard bench for gpu_wb_bridge (4-target/latency-3 and 3-target/latency-1 builds)
module tb_gpu_wb_bridge;

    logic clk_100MHz = 1'b0;
    logic reset_n    = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    logic        cyc_a = 0, stb_a = 0, we_a = 0;
    logic [3:0]  sel_a = 0;
    logic [26:0] adr_a = 0;
    logic [31:0] dati_a = 0, dato_a;
    logic        ack_a, err_a;
    logic [3:0]  twe_a, tre_a, tsel_a;
    logic [26:0] taddr_a;
    logic [31:0] twdata_a;
    logic [127:0] rdata_a;

    logic        cyc_b = 0, stb_b = 0, we_b = 0;
    logic [3:0]  sel_b = 0;
    logic [26:0] adr_b = 0;
    logic [31:0] dati_b = 0, dato_b;
    logic        ack_b, err_b;
    logic [2:0]  twe_b, tre_b;
    logic [3:0]  tsel_b;
    logic [26:0] taddr_b;
    logic [31:0] twdata_b;
    logic [95:0] rdata_b;

    gpu_wb_bridge #(.ADDR_W(27), .NUM_TGT(4), .DEC_LSB(12), .READ_LATENCY(3)) dut_a (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n),
        .wb_cyc_i(cyc_a), .wb_stb_i(stb_a), .wb_we_i(we_a), .wb_sel_i(sel_a),
        .wb_adr_i(adr_a), .wb_dat_i(dati_a), .wb_dat_o(dato_a), .wb_ack_o(ack_a),
        .wb_err_o(err_a), .o_tgt_we(twe_a), .o_tgt_re(tre_a), .o_tgt_addr(taddr_a),
        .o_tgt_wdata(twdata_a), .o_tgt_sel(tsel_a), .i_tgt_rdata(rdata_a)
    );

    gpu_wb_bridge #(.ADDR_W(27), .NUM_TGT(3), .DEC_LSB(12), .READ_LATENCY(1)) dut_b (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n),
        .wb_cyc_i(cyc_b), .wb_stb_i(stb_b), .wb_we_i(we_b), .wb_sel_i(sel_b),
        .wb_adr_i(adr_b), .wb_dat_i(dati_b), .wb_dat_o(dato_b), .wb_ack_o(ack_b),
        .wb_err_o(err_b), .o_tgt_we(twe_b), .o_tgt_re(tre_b), .o_tgt_addr(taddr_b),
        .o_tgt_wdata(twdata_b), .o_tgt_sel(tsel_b), .i_tgt_rdata(rdata_b)
    );

    // Synchronous-RAM targets: data is valid exactly READ_LATENCY cycles after the read strobe.
    logic [3:0] h_a [3];
    logic [2:0] h_b;
    always @(posedge clk_100MHz) begin
        h_a[0] <= tre_a;
        h_a[1] <= h_a[0];
        h_a[2] <= h_a[1];
        h_b    <= tre_b;
    end

    function automatic logic [31:0] val_a(input int t);
        case (t)
            0:       return 32'h0A0A0A0A;
            1:       return 32'hCAFEF00D;
            2:       return 32'h5555AAAA;
            default: return 32'h12345678;
        endcase
    endfunction

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int t = 0; t < 4; t++)
            rdata_a[t*32 +: 32] = h_a[2][t] ? val_a(t) : (32'hBAD00000 | 32'(t));
        for (int t = 0; t < 3; t++)
            rdata_b[t*32 +: 32] = h_b[t] ? (32'h0B0B0B00 | 32'(t)) : (32'hBAD10000 | 32'(t));
    end

    typedef struct { int cyc; logic [31:0] dat; logic err; } resp_t;
    typedef struct { int cyc; logic [3:0] we; logic [3:0] re; logic [26:0] addr; logic [31:0] wdata; logic [3:0] sel; } strb_t;

    resp_t rq_a[$], rq_b[$];
    strb_t sq_a[$], sq_b[$];
    resp_t ra, rb;
    strb_t sa, sb;
    int checks = 0, failures = 0, cyc_n = 0;
    bit prev_a = 0, prev_b = 0;

    always @(posedge clk_100MHz) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    always @(negedge clk_100MHz) if (reset_n) begin
        if (ack_a | err_a) begin
            chk("a_ack_not_consecutive", 64'(prev_a), 64'(0));
            chk("a_resp_expected", 64'(rq_a.size() != 0), 64'(1));
            if (rq_a.size() != 0) begin
                ra = rq_a.pop_front();
                chk("a_resp_cycle", 64'(cyc_n), 64'(ra.cyc));
                chk("a_resp_dat", 64'(dato_a), 64'(ra.dat));
                chk("a_resp_kind", 64'({ack_a, err_a}), 64'({~ra.err, ra.err}));
            end
        end
        prev_a = ack_a | err_a;
        if ((twe_a | tre_a) != 4'd0) begin
            chk("a_strobe_onehot", 64'($countones({twe_a, tre_a})), 64'(1));
            chk("a_strobe_expected", 64'(sq_a.size() != 0), 64'(1));
            if (sq_a.size() != 0) begin
                sa = sq_a.pop_front();
                chk("a_strobe_cycle", 64'(cyc_n), 64'(sa.cyc));
                chk("a_strobe_vec", 64'({twe_a, tre_a}), 64'({sa.we, sa.re}));
                chk("a_strobe_payload", 64'({taddr_a, twdata_a, tsel_a}), 64'({sa.addr, sa.wdata, sa.sel}));
            end
        end
    end

    always @(negedge clk_100MHz) if (reset_n) begin
        if (ack_b | err_b) begin
            chk("b_ack_not_consecutive", 64'(prev_b), 64'(0));
            chk("b_resp_expected", 64'(rq_b.size() != 0), 64'(1));
            if (rq_b.size() != 0) begin
                rb = rq_b.pop_front();
                chk("b_resp_cycle", 64'(cyc_n), 64'(rb.cyc));
                chk("b_resp_dat", 64'(dato_b), 64'(rb.dat));
                chk("b_resp_kind", 64'({ack_b, err_b}), 64'({~rb.err, rb.err}));
            end
        end
        prev_b = ack_b | err_b;
        if ((twe_b | tre_b) != 3'd0) begin
            chk("b_strobe_onehot", 64'($countones({twe_b, tre_b})), 64'(1));
            chk("b_strobe_expected", 64'(sq_b.size() != 0), 64'(1));
            if (sq_b.size() != 0) begin
                sb = sq_b.pop_front();
                chk("b_strobe_cycle", 64'(cyc_n), 64'(sb.cyc));
                chk("b_strobe_vec", 64'({1'b0, twe_b, 1'b0, tre_b}), 64'({sb.we, sb.re}));
                chk("b_strobe_payload", 64'({taddr_b, twdata_b, tsel_b}), 64'({sb.addr, sb.wdata, sb.sel}));
            end
        end
    end

    task automatic drive(input int inst, input bit c, input bit we, input logic [26:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        if (inst == 0) begin
            cyc_a = c; stb_a = c; we_a = we; adr_a = adr; dati_a = dat; sel_a = sel;
        end else begin
            cyc_b = c; stb_b = c; we_b = we; adr_b = adr; dati_b = dat; sel_b = sel;
        end
    endtask

    // b2b: called in the ack cycle of the previous transfer with stb still held.
    task automatic txn(input int inst, input bit we, input logic [26:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [3:0] oh, input logic [31:0] exp_dat,
                       input bit exp_err, input int lat, input bit b2b, input bit drop);
        int c;
        int n;
        resp_t r;
        strb_t s;
        if (!b2b) @(negedge clk_100MHz);
        c = cyc_n + (b2b ? 1 : 0);
        drive(inst, 1'b1, we, adr, dat, sel);
        r.cyc = we ? c + 2 : c + lat + 2;
        r.dat = exp_dat;
        r.err = exp_err;
        if (inst == 0) rq_a.push_back(r); else rq_b.push_back(r);
        if (oh != 4'd0) begin
            s.cyc = we ? c + 2 : c + 1;
            s.we = we ? oh : 4'd0;
            s.re = we ? 4'd0 : oh;
            s.addr = adr; s.wdata = dat; s.sel = sel;
            if (inst == 0) sq_a.push_back(s); else sq_b.push_back(s);
        end
        for (n = 0; n < 30; n++) begin
            @(negedge clk_100MHz);
            if (inst == 0 ? (ack_a | err_a) : (ack_b | err_b)) break;
        end
        chk("txn_done_in_budget", 64'(n < 30), 64'(1));
        if (drop) drive(inst, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic chk_a_idle(input string name);
        chk(name, 64'({ack_a, err_a, twe_a, tre_a, tsel_a}), 64'(0));
        chk(name, 64'({taddr_a, twdata_a}), 64'(0));
        chk(name, 64'(dato_a), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        strb_t s;
        repeat (5) @(negedge clk_100MHz);
        chk_a_idle("reset_state_a");
        chk("reset_state_b", 64'({ack_b, err_b, twe_b, tre_b, tsel_b, dato_b}), 64'(0));
        reset_n = 1'b1;
        @(negedge clk_100MHz);

        txn(0, 1, 27'h0001004, 32'hDEADBEEF, 4'hF, 4'b0010, 32'h0, 0, 3, 0, 1);
        txn(0, 0, 27'h0003000, 32'h0, 4'hF, 4'b1000, 32'h12345678, 0, 3, 0, 1);
        txn(0, 1, 27'h7FF2ABC, 32'h0BADF00D, 4'h5, 4'b0100, 32'h0, 0, 3, 0, 1);
        txn(0, 0, 27'h5A01010, 32'h0, 4'h3, 4'b0010, 32'hCAFEF00D, 0, 3, 0, 1);

        txn(1, 1, 27'h0000008, 32'hA5A5A5A5, 4'hF, 4'b0001, 32'h0, 0, 1, 0, 1);
        txn(1, 0, 27'h0002010, 32'h0, 4'hF, 4'b0100, 32'h0B0B0B02, 0, 1, 0, 1);
`ifdef WB_ERR_EN
        txn(1, 1, 27'h0003004, 32'h77777777, 4'hF, 4'b0000, 32'h0, 1, 0, 0, 1);
        txn(1, 0, 27'h0003000, 32'h0, 4'hF, 4'b0000, 32'h00000001, 0, 0, 0, 1);
`else
        txn(1, 1, 27'h0003004, 32'h77777777, 4'hF, 4'b0000, 32'h0, 0, 0, 0, 1);
        txn(1, 0, 27'h0003000, 32'h0, 4'hF, 4'b0000, 32'h0, 0, 0, 0, 1);
`endif

        // Abort: cyc drops the cycle after the read strobe; no termination may follow.
        @(negedge clk_100MHz);
        c = cyc_n;
        drive(0, 1'b1, 1'b0, 27'h0002000, 32'h0, 4'hF);
        s.cyc = c + 1; s.we = 4'd0; s.re = 4'b0100; s.addr = 27'h0002000; s.wdata = 32'h0; s.sel = 4'hF;
        sq_a.push_back(s);
        repeat (2) @(negedge clk_100MHz);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        repeat (8) @(negedge clk_100MHz);
        txn(0, 1, 27'h0000100, 32'h13572468, 4'hC, 4'b0001, 32'h0, 0, 3, 0, 1);

        // Reset while the read latency counter is running.
        @(negedge clk_100MHz);
        c = cyc_n;
        drive(0, 1'b1, 1'b0, 27'h0000040, 32'h0, 4'hF);
        s.cyc = c + 1; s.we = 4'd0; s.re = 4'b0001; s.addr = 27'h0000040; s.wdata = 32'h0; s.sel = 4'hF;
        sq_a.push_back(s);
        repeat (2) @(negedge clk_100MHz);
        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk_100MHz);
        chk_a_idle("reset_mid_read_a");
        reset_n = 1'b1;
        repeat (4) @(negedge clk_100MHz);
        txn(0, 0, 27'h0003000, 32'h0, 4'hF, 4'b1000, 32'h12345678, 0, 3, 0, 1);

        // Back-to-back with stb held through each ack, alternating direction.
        txn(0, 1, 27'h0000010, 32'h11111111, 4'hF, 4'b0001, 32'h0, 0, 3, 0, 0);
        txn(0, 0, 27'h0001020, 32'h0, 4'hF, 4'b0010, 32'hCAFEF00D, 0, 3, 1, 0);
        txn(0, 1, 27'h0002030, 32'h22222222, 4'h3, 4'b0100, 32'h0, 0, 3, 1, 1);

        repeat (10) @(negedge clk_100MHz);
        chk("a_resp_queue_drained", 64'(rq_a.size()), 64'(0));
        chk("a_strobe_queue_drained", 64'(sq_a.size()), 64'(0));
        chk("b_resp_queue_drained", 64'(rq_b.size()), 64'(0));
        chk("b_strobe_queue_drained", 64'(sq_b.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpu_wb_bridge.md
Name: gpu_wb_bridge

Overview:
- Parametrised Wishbone-classic slave front end for the GPU. Replaces the ad-hoc write-only decode and divide-by-2 ack.
- Decodes a register-mapped address into NUM_TGT target regions (CR, sprite memory, tile map, texture memory, …).
- Issues single-cycle write or read strobes to the selected target.
- Handles synchronous-RAM read latency and returns a proper registered ack for both reads and writes.

Parameters:
- ADDR_W, 27, Wishbone address width.
- NUM_TGT, 4, number of target regions (1..16).
- DEC_LSB, 12, lowest address bit of the region-index field; field width is TGT_IDX_W = clog2(NUM_TGT), minimum 1.
- READ_LATENCY, 1, cycles from o_tgt_re to valid i_tgt_rdata (1..7).

Ports:
- clk_100MHz  in  1  clock
- reset_n  in  1  synchronous active-low reset
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_sel_i  in  4  byte lane select
- wb_adr_i  in  ADDR_W  address
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, valid with ack
- wb_ack_o  out  1  transfer done
- wb_err_o  out  1  error termination (constant 0 unless WB_ERR_EN)
- o_tgt_we  out  NUM_TGT  one-hot write strobe
- o_tgt_re  out  NUM_TGT  one-hot read strobe
- o_tgt_addr  out  ADDR_W  latched address
- o_tgt_wdata  out  32  latched write data
- o_tgt_sel  out  4  latched byte select
- i_tgt_rdata  in  NUM_TGT*32  per-target read data; target t occupies bits [t*32+31 : t*32]

Behaviour:
- Clock and reset: clk_100MHz, with reset_n as a synchronous, active-low reset.
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Latency counter 0.
- Region index: idx = wb_adr_i[DEC_LSB+TGT_IDX_W-1 : DEC_LSB].
  - idx >= NUM_TGT is unmapped.
  - Index is sampled once, in IDLE.
- IDLE:
  - On wb_cyc_i & wb_stb_i, latch adr/dat/sel/we/idx into o_tgt_*.
  - Mapped write → WR. Mapped read → RD. Unmapped → UNM.
- WR (1 cycle): o_tgt_we[idx] = 1 and wb_ack_o = 1 in the same cycle. Next state IDLE.
  - Write transfer = 2 cycles from request sample to ack.
- RD:
  - First cycle: o_tgt_re[idx] = 1 for exactly one cycle; counter loads READ_LATENCY.
  - Counter decrements each cycle.
  - When the counter reaches 0, capture i_tgt_rdata slice idx into wb_dat_o → ACK.
- ACK (1 cycle): wb_ack_o = 1, wb_dat_o held. Next state IDLE.
  - Read ack is READ_LATENCY+2 cycles after the request sample.
- UNM (1 cycle): no target strobe. Next state IDLE.
  - Without WB_ERR_EN: wb_ack_o = 1 and wb_dat_o = 0.
- Strobe and ack shape:
  - wb_ack_o and wb_err_o are registered and never high for two consecutive cycles.
  - At most one bit across o_tgt_we | o_tgt_re is ever set.
- Master holding stb after ack: the request is re-sampled only in IDLE, i.e. the cycle after ack. The master must drop stb in that cycle; if it does not, the bridge starts a new transfer (classic back-to-back).
- wb_cyc_i low during RD: abort, return to IDLE at the next edge, no ack. The already-issued read strobe is harmless.
- wb_dat_o clears to 0 on return to IDLE.
- reset_n low in any state: IDLE next edge, all strobes and acks deasserted immediately at that edge.
- Writes/reads to address bits outside the decode field are passed through unchanged on o_tgt_addr. Targets do their own sub-decode.

Optional Feature:
- Macro WB_ERR_EN.
- Defined: UNM asserts wb_err_o = 1 for one cycle instead of wb_ack_o.
  - A sticky status bit counts unmapped accesses in an 8-bit saturating counter, readable through region index NUM_TGT when NUM_TGT < 2^TGT_IDX_W. That access is acked with data {24'h0, count}; otherwise the counter is not readable.
- Undefined: wb_err_o is tied 0 and unmapped accesses are acked with zero data.

Decomposition:
- Package gpu_bus_pkg:
  - State enum {IDLE, WR, RD, ACK, UNM}.
  - WB_DATA_W = 32, WB_SEL_W = 4.
  - clog2 function.
- One natural sub-module, gpu_wb_addr_decode: combinational idx → one-hot plus mapped flag. Reused by future bus fabrics.

Test Plan:
- NUM_TGT=4, write adr 0x0001004 data 0xDEADBEEF sel 0xF → o_tgt_we = 4'b0010 for 1 cycle with o_tgt_wdata = 0xDEADBEEF; ack 2 cycles after request; no other strobe.
- READ_LATENCY=3, read adr 0x0003000, target 3 drives 0x12345678 on the cycle its counter expires → o_tgt_re = 4'b1000 for 1 cycle; ack + dat 0x12345678 exactly 5 cycles after request.
- NUM_TGT=3, access idx 3 → no strobe; ack with dat 0 (macro off) or wb_err_o = 1, no ack (WB_ERR_EN).
- Read in progress, drop wb_cyc_i one cycle after o_tgt_re → no ack/err ever; next write completes normally in 2 cycles.
- Assert reset_n = 0 in the RD counting cycle → all outputs 0 next edge; after release, a read completes with the correct latency.
- Back-to-back: stb held through ack with alternating we → alternating WR/RD transfers, each acked once, strobes never overlapping.
